// File: rtl/spi_slave_bus_bridge.sv
// SPI-slave (mode 0, oversampled in sys_clk) to register-bus bridge: R/W, address, dummy, data frames.
// Optional auto-increment burst mode is enabled by defining SPI_BRIDGE_BURST_EN.
module spi_slave_bus_bridge #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 16,
  parameter int DUMMY_CYCLES = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_MAX = (ADDR_W > DATA_W) ?
                           ((ADDR_W > DUMMY_CYCLES) ? ADDR_W : DUMMY_CYCLES) :
                           ((DATA_W > DUMMY_CYCLES) ? DATA_W : DUMMY_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4
  } state_t;

  state_t              state_r;
  logic [2:0]          sck_sync_r;
  logic [2:0]          cs_sync_r;
  logic [1:0]          mosi_sync_r;
  logic                sck_rise_s;
  logic                cs_fall_s;
  logic                cs_rise_s;
  logic                mosi_s;
  logic                is_read_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [ADDR_W-1:0]   addr_shift_r;
  logic [DATA_W-1:0]   rx_shift_r;
  logic [DATA_W-1:0]   tx_shift_r;
  logic [LAT_W-1:0]    lat_cnt_r;
  logic                re_pend_r;
  logic                we_pend_r;
  logic                word_done_r;
`ifdef SPI_BRIDGE_BURST_EN
  logic [DATA_W-1:0]   prefetch_r;
  logic                pf_pend_r;
  logic                rd_to_pf_r;
  logic                inc_pend_r;
`endif

  // Edges come from stages 2/3 so each pin sees two metastability-settling flops first.
  assign sck_rise_s = sck_sync_r[1] & ~sck_sync_r[2];
  assign cs_fall_s  = ~cs_sync_r[1] & cs_sync_r[2];
  assign cs_rise_s  = cs_sync_r[1] & ~cs_sync_r[2];
  assign mosi_s     = mosi_sync_r[1];

  // Pin synchronisers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi_clk};
      cs_sync_r   <= {cs_sync_r[1:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
    end
  end

  // Frame decoder, bus strobes and read-data shifter.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      is_read_r    <= 1'b0;
      bit_cnt_r    <= {CNT_W{1'b0}};
      addr_shift_r <= {ADDR_W{1'b0}};
      rx_shift_r   <= {DATA_W{1'b0}};
      tx_shift_r   <= {DATA_W{1'b0}};
      lat_cnt_r    <= {LAT_W{1'b0}};
      re_pend_r    <= 1'b0;
      we_pend_r    <= 1'b0;
      word_done_r  <= 1'b0;
      spi_miso     <= 1'b0;
      bus_addr     <= {ADDR_W{1'b0}};
      bus_wdata    <= {DATA_W{1'b0}};
      bus_we       <= 1'b0;
      bus_re       <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
`ifdef SPI_BRIDGE_BURST_EN
      prefetch_r   <= {DATA_W{1'b0}};
      pf_pend_r    <= 1'b0;
      rd_to_pf_r   <= 1'b0;
      inc_pend_r   <= 1'b0;
`endif
    end else begin
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      frame_err <= 1'b0;

      if (we_pend_r) begin
        bus_we    <= 1'b1;
        bus_wdata <= rx_shift_r;
        we_pend_r <= 1'b0;
`ifdef SPI_BRIDGE_BURST_EN
        inc_pend_r <= 1'b1;
`endif
      end

      if (re_pend_r) begin
        bus_re    <= 1'b1;
        re_pend_r <= 1'b0;
      end

`ifdef SPI_BRIDGE_BURST_EN
      // Address moves on only after the write strobe has used it.
      if (inc_pend_r) begin
        bus_addr   <= bus_addr + ADDR_W'(1);
        inc_pend_r <= 1'b0;
      end
      if (pf_pend_r) begin
        bus_re     <= 1'b1;
        bus_addr   <= bus_addr + ADDR_W'(1);
        rd_to_pf_r <= 1'b1;
        pf_pend_r  <= 1'b0;
      end
`endif

      if (bus_re) begin
        lat_cnt_r <= LAT_W'(READ_LATENCY);
      end else if (lat_cnt_r != {LAT_W{1'b0}}) begin
        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
      end

      if (lat_cnt_r == LAT_W'(1)) begin
`ifdef SPI_BRIDGE_BURST_EN
        if (rd_to_pf_r) begin
          prefetch_r <= bus_rdata;
        end else begin
          tx_shift_r <= bus_rdata;
          spi_miso   <= bus_rdata[DATA_W-1];
          pf_pend_r  <= 1'b1;
        end
`else
        tx_shift_r <= bus_rdata;
        spi_miso   <= bus_rdata[DATA_W-1];
`endif
      end

      if (cs_rise_s) begin
        if ((state_r != IDLE) && !word_done_r) begin
          frame_err <= 1'b1;
        end
        state_r     <= IDLE;
        busy        <= 1'b0;
        word_done_r <= 1'b0;
        bit_cnt_r   <= {CNT_W{1'b0}};
        tx_shift_r  <= {DATA_W{1'b0}};
        spi_miso    <= 1'b0;
        re_pend_r   <= 1'b0;
`ifdef SPI_BRIDGE_BURST_EN
        pf_pend_r   <= 1'b0;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (cs_fall_s) begin
              state_r     <= CMD;
              busy        <= 1'b1;
              bit_cnt_r   <= {CNT_W{1'b0}};
              word_done_r <= 1'b0;
            end
          end
          CMD: begin
            if (sck_rise_s) begin
              is_read_r <= mosi_s;
              bit_cnt_r <= {CNT_W{1'b0}};
              state_r   <= ADDR;
            end
          end
          ADDR: begin
            if (sck_rise_s) begin
              addr_shift_r <= {addr_shift_r[ADDR_W-2:0], mosi_s};
              if (bit_cnt_r == CNT_W'(ADDR_W - 1)) begin
                bus_addr  <= {addr_shift_r[ADDR_W-2:0], mosi_s};
                re_pend_r <= is_read_r;
                bit_cnt_r <= {CNT_W{1'b0}};
                state_r   <= DUMMY;
`ifdef SPI_BRIDGE_BURST_EN
                rd_to_pf_r <= 1'b0;
`endif
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          DUMMY: begin
            if (sck_rise_s) begin
              if (bit_cnt_r == CNT_W'(DUMMY_CYCLES - 1)) begin
                bit_cnt_r <= {CNT_W{1'b0}};
                state_r   <= DATA;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sck_rise_s) begin
`ifdef SPI_BRIDGE_BURST_EN
              rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
              // First rise of a follow-on word swaps in the prefetched word instead of shifting.
              if (bit_cnt_r == {CNT_W{1'b0}}) begin
                if (word_done_r && is_read_r) begin
                  tx_shift_r <= prefetch_r;
                  spi_miso   <= prefetch_r[DATA_W-1];
                  pf_pend_r  <= 1'b1;
                end
              end else begin
                tx_shift_r <= tx_shift_r << 1;
                spi_miso   <= tx_shift_r[DATA_W-2];
              end
              if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                word_done_r <= 1'b1;
                we_pend_r   <= ~is_read_r;
                bit_cnt_r   <= {CNT_W{1'b0}};
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
`else
              // Bits beyond the first word are swallowed silently.
              if (word_done_r) begin
                tx_shift_r <= {DATA_W{1'b0}};
                spi_miso   <= 1'b0;
              end else begin
                rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
                if (bit_cnt_r != {CNT_W{1'b0}}) begin
                  tx_shift_r <= tx_shift_r << 1;
                  spi_miso   <= tx_shift_r[DATA_W-2];
                end
                if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                  word_done_r <= 1'b1;
                  we_pend_r   <= ~is_read_r;
                  bit_cnt_r   <= {CNT_W{1'b0}};
                end else begin
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
              end
`endif
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bus_bridge.sv
// Directed self-checking bench for spi_slave_bus_bridge with a one-cycle-latency register-file model.
// Burst scenarios run only when SPI_BRIDGE_BURST_EN is defined.
module tb_spi_slave_bus_bridge;

  logic        clk;
  logic        rst;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_rdata;
  logic        busy;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:127];
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  logic [6:0]  we_addr_log [0:15];
  logic [15:0] we_data_log [0:15];
  logic [6:0]  re_addr_log [0:15];

`ifdef SPI_BRIDGE_BURST_EN
  localparam int RE_PER_READ = 2;
`else
  localparam int RE_PER_READ = 1;
`endif

  spi_slave_bus_bridge dut (
    .sys_clk   (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: data valid one cycle after bus_re.
  always @(posedge clk) begin
    if (bus_re) bus_rdata <= mem[bus_addr];
    if (bus_we) mem[bus_addr] <= bus_wdata;
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_we && bus_re) both_cnt++;
    if (bus_we) begin
      if (we_cnt < 16) begin
        we_addr_log[we_cnt] = bus_addr;
        we_data_log[we_cnt] = bus_wdata;
      end
      we_cnt++;
    end
    if (bus_re) begin
      if (re_cnt < 16) re_addr_log[re_cnt] = bus_addr;
      re_cnt++;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic cs_high();
    wait_clks(8);
    spi_cs_n = 1'b1;
    wait_clks(12);
  endtask

  // One SCK period: MOSI set while low, MISO sampled just before the falling edge.
  task automatic send_bit(input logic b, output logic s);
    spi_mosi = b;
    wait_clks(8);
    spi_clk = 1'b1;
    wait_clks(8);
    s = spi_miso;
    spi_clk = 1'b0;
  endtask

  task automatic send_header(input logic rw, input logic [6:0] addr, input int ndummy);
    logic s;
    send_bit(rw, s);
    for (int i = 6; i >= 0; i--) send_bit(addr[i], s);
    for (int i = 0; i < ndummy; i++) send_bit(1'b0, s);
  endtask

  task automatic send_data(input int ndata, input logic [63:0] wd, output logic [63:0] rd);
    logic s;
    rd = 64'h0;
    for (int i = 0; i < ndata; i++) begin
      send_bit(wd[63-i], s);
      rd = {rd[62:0], s};
    end
  endtask

  task automatic spi_xfer(input logic rw, input logic [6:0] addr, input int ndata,
                          input logic [63:0] wd, output logic [63:0] rd);
    cs_low();
    send_header(rw, addr, 10);
    send_data(ndata, wd, rd);
    cs_high();
  endtask

  logic [15:0] pats [0:6];
  logic [63:0] rd;
  int          we0, re0, err0;

  initial begin
    pats[0] = 16'hAAAA; pats[1] = 16'h5555; pats[2] = 16'h0000; pats[3] = 16'h0001;
    pats[4] = 16'h8000; pats[5] = 16'hFFFF; pats[6] = 16'h2A2A;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[7'h19] = 16'h0001;
    mem[7'h10] = 16'hBEEF;
    mem[7'h11] = 16'h1357;
    bus_rdata = 16'h0000;
    rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clks(3);
    check_eq("rst_miso", {63'h0, spi_miso}, 64'h0);
    check_eq("rst_addr", {57'h0, bus_addr}, 64'h0);
    check_eq("rst_wdata", {48'h0, bus_wdata}, 64'h0);
    check_eq("rst_we", {63'h0, bus_we}, 64'h0);
    check_eq("rst_re", {63'h0, bus_re}, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_err", {63'h0, frame_err}, 64'h0);
    rst = 1'b0;
    wait_clks(4);

    // Write then read back address 0 for each pattern.
    for (int p = 0; p < 7; p++) begin
      we0 = we_cnt; re0 = re_cnt;
      spi_xfer(1'b0, 7'h00, 16, {pats[p], 48'h0}, rd);
      check_eq("wr_we_count", 64'(we_cnt - we0), 64'd1);
      check_eq("wr_addr", {57'h0, we_addr_log[we0]}, 64'h00);
      check_eq("wr_data", {48'h0, we_data_log[we0]}, {48'h0, pats[p]});
      check_eq("wr_no_re", 64'(re_cnt - re0), 64'd0);
      we0 = we_cnt; re0 = re_cnt;
      spi_xfer(1'b1, 7'h00, 16, 64'h0, rd);
      check_eq("rd_data", {48'h0, rd[15:0]}, {48'h0, pats[p]});
      check_eq("rd_re_count", 64'(re_cnt - re0), 64'(RE_PER_READ));
      check_eq("rd_re_addr", {57'h0, re_addr_log[re0]}, 64'h00);
      check_eq("rd_no_we", 64'(we_cnt - we0), 64'd0);
    end

    // Read of a model-preset register.
    we0 = we_cnt; re0 = re_cnt;
    spi_xfer(1'b1, 7'h19, 16, {16'hFFFF, 48'h0}, rd);
    check_eq("rd19_data", {48'h0, rd[15:0]}, 64'h0001);
    check_eq("rd19_re_count", 64'(re_cnt - re0), 64'(RE_PER_READ));
    check_eq("rd19_re_addr", {57'h0, re_addr_log[re0]}, 64'h19);
    check_eq("rd19_no_we", 64'(we_cnt - we0), 64'd0);

    // Aborted write after 9 data bits, then a good write.
    we0 = we_cnt; err0 = err_cnt;
    spi_xfer(1'b0, 7'h07, 9, {16'hFFFF, 48'h0}, rd);
    check_eq("abort_err", 64'(err_cnt - err0), 64'd1);
    check_eq("abort_no_we", 64'(we_cnt - we0), 64'd0);
    check_eq("abort_busy", {63'h0, busy}, 64'h0);
    we0 = we_cnt; err0 = err_cnt;
    spi_xfer(1'b0, 7'h07, 16, {16'h1234, 48'h0}, rd);
    check_eq("after_abort_we", 64'(we_cnt - we0), 64'd1);
    check_eq("after_abort_addr", {57'h0, we_addr_log[we0]}, 64'h07);
    check_eq("after_abort_data", {48'h0, we_data_log[we0]}, 64'h1234);
    check_eq("after_abort_err", 64'(err_cnt - err0), 64'd0);

`ifdef SPI_BRIDGE_BURST_EN
    // Burst write wraps from the top address.
    we0 = we_cnt; err0 = err_cnt;
    spi_xfer(1'b0, 7'h7F, 48, {16'h1111, 16'h2222, 16'h3333, 16'h0}, rd);
    check_eq("bw_we_count", 64'(we_cnt - we0), 64'd3);
    check_eq("bw_addr0", {57'h0, we_addr_log[we0]}, 64'h7F);
    check_eq("bw_data0", {48'h0, we_data_log[we0]}, 64'h1111);
    check_eq("bw_addr1", {57'h0, we_addr_log[we0+1]}, 64'h00);
    check_eq("bw_data1", {48'h0, we_data_log[we0+1]}, 64'h2222);
    check_eq("bw_addr2", {57'h0, we_addr_log[we0+2]}, 64'h01);
    check_eq("bw_data2", {48'h0, we_data_log[we0+2]}, 64'h3333);
    check_eq("bw_err", 64'(err_cnt - err0), 64'd0);
    we0 = we_cnt;
    spi_xfer(1'b1, 7'h10, 32, 64'h0, rd);
    check_eq("br_data", {32'h0, rd[31:0]}, 64'hBEEF1357);
    check_eq("br_no_we", 64'(we_cnt - we0), 64'd0);
`else
    // Extra bits after one word: single strobe, no error, MISO idles low.
    we0 = we_cnt; err0 = err_cnt;
    spi_xfer(1'b0, 7'h05, 32, {16'hC0DE, 16'hFFFF, 32'h0}, rd);
    check_eq("long_we_count", 64'(we_cnt - we0), 64'd1);
    check_eq("long_addr", {57'h0, we_addr_log[we0]}, 64'h05);
    check_eq("long_data", {48'h0, we_data_log[we0]}, 64'hC0DE);
    check_eq("long_err", 64'(err_cnt - err0), 64'd0);
    spi_xfer(1'b1, 7'h19, 32, 64'h0, rd);
    check_eq("long_rd", {32'h0, rd[31:0]}, 64'h00010000);
`endif

    // Reset in the middle of the dummy phase of a write.
    we0 = we_cnt; err0 = err_cnt;
    cs_low();
    send_header(1'b0, 7'h03, 4);
    check_eq("mid_busy", {63'h0, busy}, 64'h1);
    check_eq("mid_addr", {57'h0, bus_addr}, 64'h03);
    rst = 1'b1;
    #1;
    check_eq("mrst_busy", {63'h0, busy}, 64'h0);
    check_eq("mrst_addr", {57'h0, bus_addr}, 64'h0);
    check_eq("mrst_wdata", {48'h0, bus_wdata}, 64'h0);
    check_eq("mrst_miso", {63'h0, spi_miso}, 64'h0);
    wait_clks(2);
    rst = 1'b0;
    send_header(1'b0, 7'h7F, 0);
    send_data(16, {16'h9999, 48'h0}, rd);
    cs_high();
    check_eq("mrst_no_we", 64'(we_cnt - we0), 64'd0);
    check_eq("mrst_no_err", 64'(err_cnt - err0), 64'd0);
    spi_xfer(1'b0, 7'h03, 16, {16'h4321, 48'h0}, rd);
    check_eq("post_rst_we", 64'(we_cnt - we0), 64'd1);
    check_eq("post_rst_addr", {57'h0, we_addr_log[we0]}, 64'h03);
    check_eq("post_rst_data", {48'h0, we_data_log[we0]}, 64'h4321);

    check_eq("we_re_overlap", 64'(both_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
